// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential 16x16 multiplier.
package mult_pkg;

   localparam int unsigned MULT_N      = 16;
   localparam int unsigned MULT_CNT_W  = 4;
   localparam logic [MULT_CNT_W-1:0] MULT_LAST = 4'hF;

   typedef enum logic [1:0] {
      MULT_IDLE = 2'b00,
      MULT_BUSY = 2'b01,
      MULT_DONE = 2'b10
   } mult_state_e;

endpackage

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder.
// Ports: a, b (addends), c_in (carry in) -> s (sum), c_out (carry out).
module rca_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] s,
   output logic        c_out
);

   logic carry;

   // Bit-serial carry chain, LSB first.
   always_comb begin
      carry = c_in;
      s     = '0;
      for (int i = 0; i < 16; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out = carry;
   end

endmodule

// File: rtl/mult_16b_seq.sv
// Iterative unsigned 16x16 shift-add multiplier, one rca_16b add per cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/product result handshake; busy while iterating.
module mult_16b_seq
   import mult_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MULT_N-1:0]   a,
   input  logic [MULT_N-1:0]   b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*MULT_N-1:0] product,
   output logic                busy
);

   localparam int unsigned N     = MULT_N;
   localparam int unsigned CNT_W = MULT_CNT_W;

   mult_state_e          state_q, state_d;
   logic [2*N-1:0]       acc_q, acc_d;
   logic [N-1:0]         mcand_q, mcand_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 in_ready_q, in_ready_d;
   logic                 busy_q, busy_d;
   logic                 out_valid_q, out_valid_d;

   logic [N-1:0]         addend;
   logic [N-1:0]         sum;
   logic                 carry;

   // Upper half of the accumulator plus the multiplicand when the current
   // multiplier bit (acc[0]) is set.
   assign addend = acc_q[0] ? mcand_q : N'(0);

   rca_16b u_rca (
      .a     (acc_q[2*N-1:N]),
      .b     (addend),
      .c_in  (1'b0),
      .s     (sum),
      .c_out (carry)
   );

   // Next-state, datapath and output decode.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;

      case (state_q)
         MULT_IDLE: begin
            if (in_valid) begin
               mcand_d = a;
               acc_d   = {N'(0), b};
               cnt_d   = '0;
               state_d = MULT_BUSY;
            end
         end
         MULT_BUSY: begin
            // Carry lands in acc[31] as the whole accumulator shifts right.
            acc_d = {carry, sum, acc_q[N-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == MULT_LAST) begin
               state_d = MULT_DONE;
            end
         end
         MULT_DONE: begin
            if (out_ready) begin
               state_d = MULT_IDLE;
            end
         end
         default: begin
            state_d = MULT_IDLE;
         end
      endcase

      in_ready_d  = (state_d == MULT_IDLE);
      busy_d      = (state_d == MULT_BUSY);
      out_valid_d = (state_d == MULT_DONE);
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MULT_IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign product   = acc_q;

endmodule

// File: tb/tb_mult_16b_seq.sv
// Self-checking bench for mult_16b_seq against a plain a*b reference.
module tb_mult_16b_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mult_16b_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      return 32'(x) * 32'(y);
   endfunction

   // Wait (on negedges) for out_valid; returns cycles since the accept edge.
   // Stray operands are driven meanwhile to show they are ignored.
   task automatic wait_done(input bit stray, output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         if (stray) begin
            in_valid = 1'($urandom);
            a        = 16'($urandom);
            b        = 16'($urandom);
         end
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
   endtask

   // One full operation: accept, iterate, optional stall, result handshake.
   task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input int stall);
      logic [31:0] expv;
      int          n;
      expv      = ref_mul(oa, ob);
      out_ready = (stall == 0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = oa;
      b        = ob;
      @(negedge clk);
      in_valid = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_in_ready", 32'(in_ready), 32'd0);
      wait_done(1'b1, n);
      in_valid = 1'b0;
      chk("latency", 32'(n), 32'd16);
      chk("product", product, expv);
      chk("done_busy", 32'(busy), 32'd0);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         a        = 16'hFFFF;
         b        = 16'hFFFF;
         @(negedge clk);
         chk("stall_product", product, expv);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("handshake_out_valid", 32'(out_valid), 32'd0);
      chk("handshake_in_ready", 32'(in_ready), 32'd1);
      chk("idle_product_hold", product, expv);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      a         = 16'h1111;
      b         = 16'h2222;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_product", product, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases: basic, max, zero, back-pressure with stray operands.
      do_op(16'h0003, 16'h0005, 0);
      do_op(16'hFFFF, 16'hFFFF, 0);
      do_op(16'h0000, 16'hABCD, 0);
      do_op(16'h1234, 16'h0010, 5);

      // Back-to-back with in_valid held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 16'h0100;
      b         = 16'h0100;
      @(negedge clk);
      a = 16'h0002;
      b = 16'h8000;
      chk("b2b_busy1", 32'(busy), 32'd1);
      wait_done(1'b0, n);
      chk("b2b_latency1", 32'(n), 32'd16);
      chk("b2b_product1", product, ref_mul(16'h0100, 16'h0100));
      @(negedge clk);
      chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
      chk("b2b_gap_busy", 32'(busy), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_busy2", 32'(busy), 32'd1);
      wait_done(1'b0, n);
      chk("b2b_latency2", 32'(n), 32'd16);
      chk("b2b_product2", product, ref_mul(16'h0002, 16'h8000));
      @(negedge clk);
      chk("b2b_idle", 32'(in_ready), 32'd1);

      // Asynchronous reset in the middle of an operation.
      in_valid = 1'b1;
      a        = 16'h00FF;
      b        = 16'h00FF;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_product", product, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_out_valid", 32'(out_valid), 32'd0);
      do_op(16'h0007, 16'h0009, 0);

      // Randomized operations with random back-pressure.
      for (int i = 0; i < 20; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i == 0) ra = 16'hFFFF;
         if (i == 1) rb = 16'h0000;
         do_op(ra, rb, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_16b_seq.md
Name: mult_16b_seq

Overview:
Iterative unsigned 16x16 shift-add multiplier that drives the team's 16-bit ripple-carry adder (rca_16b) once per cycle and produces a 32-bit product. It sits in the execute stage beside the ALU and serves multiply instructions that tolerate multi-cycle latency. It uses valid/ready handshakes on both the operand side and the result side, and holds one operation at a time.

Parameters:
N, 16, operand width; only 16 is supported because the adder is fixed-width
CNT_W, 4, iteration counter width (log2 N)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a and b are valid
in_ready  output  1  block can accept operands
a  input  16  multiplicand, unsigned
b  input  16  multiplier, unsigned
out_valid  output  1  product is valid
out_ready  input  1  consumer accepts the product
product  output  32  unsigned a*b
busy  output  1  iteration in progress

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n); all flops clear immediately on assertion, independent of clk.
- Reset values: state=IDLE, acc=0, mcand=0, cnt=0. Outputs during and after reset: out_valid=0, busy=0, product=0, in_ready=1. Input handshakes are ignored while rst_n is low.
- States:
  - IDLE: in_ready=1. If in_valid is high at a clk edge: mcand<=a, acc<={16'h0000,b}, cnt<=0, go to BUSY.
  - BUSY: in_ready=0, busy=1. Every cycle, rca_16b computes {c,s} = acc[31:16] + (acc[0] ? mcand : 0) with C_in=0. Then acc<={c, s, acc[15:1]} and cnt<=cnt+1. If cnt==15 at the edge, go to DONE.
  - DONE: out_valid=1, in_ready=0, busy=0. If out_ready is high at the edge, go to IDLE.
- Latency: operands are accepted at edge k. The iterations occur at edges k+1..k+16, and out_valid is high from edge k+16 onward. Latency is fixed at 16 cycles and does not depend on the data.
- product is driven directly from acc and is stable throughout DONE. It holds indefinitely under back-pressure while out_ready=0.
- There is no accept in the same cycle as the result handshake. After DONE->IDLE, the next accept occurs at the following edge at the earliest, giving a throughput of 1 operation per 18 cycles.
- in_valid or new a/b values during BUSY or DONE are ignored and do not corrupt acc.
- out_ready high outside DONE has no effect.
- Reset mid-operation (rst_n low in BUSY or DONE): the operation is aborted and no out_valid is produced. After release the block is in IDLE with product=0.
- Arithmetic: unsigned and exact, with no overflow. The adder carry becomes acc[31] after the shift. Max case: 0xFFFF*0xFFFF=0xFFFE0001.
- Illegal state encodings return to IDLE.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding constants MULT_IDLE=2'b00, MULT_BUSY=2'b01, MULT_DONE=2'b10
  - MULT_N=16
  - MULT_LAST=4'hF
- Sub-module: the existing rca_16b, instantiated once as the per-iteration adder. No other sub-modules.
- The state register, counter and accumulator stay in mult_16b_seq.

Test Plan:
1. Basic: a=0x0003, b=0x0005, in_valid pulsed one cycle in IDLE -> in_ready falls next cycle, busy high 16 cycles, out_valid 16 cycles after accept, product=0x0000000F.
2. Max operands: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001; zero case a=0x0000, b=0xABCD -> product=0x00000000 with the same 16-cycle latency.
3. Back-pressure: a=0x1234, b=0x0010, out_ready held low 5 cycles after out_valid. During the stall, also drive in_valid=1 with a=0xFFFF, b=0xFFFF -> product holds 0x00012340, in_ready=0, stray operands ignored. Then out_ready=1 -> IDLE next edge.
4. Back-to-back: in_valid held high with a=0x0100, b=0x0100, then a=0x0002, b=0x8000, out_ready=1 -> first product 0x00010000. Second accept at the edge after the DONE handshake, second product 0x00010000 16 cycles later. No overlap.
5. Reset mid-operation: a=0x00FF, b=0x00FF, rst_n pulsed low asynchronously (between clk edges) 8 cycles into BUSY -> out_valid=0, busy=0, product=0, in_ready=1 immediately. After release, a=0x0007, b=0x0009 -> product=0x0000003F.
